// File: rtl/snes_pad_responder.sv
// Controller-side SNES joypad responder: two 12-button pads on JOY_STRB / JOYx_CLK.
// Optional turbo buttons are built in when SNES_PAD_TURBO_EN is defined.
module snes_pad_responder #(
  parameter logic [3:0]  EXT_BITS   = 4'b0000,
  parameter bit          POST_LEVEL = 1'b1,
  parameter int unsigned TURBO_DIV  = 2
) (
  input  logic        MCLK,
  input  logic        RST_N,
  input  logic        JOY_STRB,
  input  logic        JOY1_CLK,
  input  logic        JOY2_CLK,
  input  logic [11:0] BTN1,
  input  logic [11:0] BTN2,
  input  logic [1:0]  CONN,
  input  logic [11:0] TURBO_MASK1,
  input  logic [11:0] TURBO_MASK2,
  output logic [1:0]  JOY1_DI,
  output logic [1:0]  JOY2_DI
);

  // Serial bit 13 sits in SR[12], so the ID nibble goes in MSB-first.
  localparam logic [3:0] EXT_REV = {EXT_BITS[0], EXT_BITS[1], EXT_BITS[2], EXT_BITS[3]};

  logic [1:0]  pad_clk;
  logic [1:0]  clk_q;
  logic [15:0] sr_q  [2];
  logic [15:0] sr_d  [2];
  logic [4:0]  cnt_q [2];
  logic [4:0]  cnt_d [2];
  logic [1:0]  data_q;
  logic [1:0]  data_d;
  logic [11:0] eff_btn [2];

  assign pad_clk = {JOY2_CLK, JOY1_CLK};

`ifdef SNES_PAD_TURBO_EN
  logic       strb_q;
  logic [7:0] div_q;
  logic       tp_q;

  always_ff @(posedge MCLK or negedge RST_N) begin
    if (!RST_N) begin
      strb_q <= 1'b0;
      div_q  <= '0;
      tp_q   <= 1'b0;
    end else begin
      strb_q <= JOY_STRB;
      if (strb_q && !JOY_STRB) begin
        if (div_q + 8'd1 == 8'(TURBO_DIV)) begin
          div_q <= '0;
          tp_q  <= ~tp_q;
        end else begin
          div_q <= div_q + 8'd1;
        end
      end
    end
  end

  // Masked buttons only show through while the phase is high.
  assign eff_btn[0] = BTN1 & ~(TURBO_MASK1 & {12{~tp_q}});
  assign eff_btn[1] = BTN2 & ~(TURBO_MASK2 & {12{~tp_q}});
`else
  logic unused_turbo;
  assign unused_turbo = &{1'b0, TURBO_MASK1, TURBO_MASK2, 8'(TURBO_DIV)};
  assign eff_btn[0]   = BTN1;
  assign eff_btn[1]   = BTN2;
`endif

  // Next-state logic; the output level is derived from next state so that
  // the data line moves on the same edge that shifts the register.
  always_comb begin
    logic lvl;
    // NOTE: every always_comb target gets a default first so no path infers a latch.
    lvl = 1'b0;
    for (int p = 0; p < 2; p++) begin
      sr_d[p]  = sr_q[p];
      cnt_d[p] = cnt_q[p];
      if (JOY_STRB) begin
        sr_d[p]  = {EXT_REV, eff_btn[p]};
        cnt_d[p] = '0;
      end else if (!clk_q[p] && pad_clk[p]) begin
        sr_d[p] = {1'b0, sr_q[p][15:1]};
        if (cnt_q[p] != 5'd16) cnt_d[p] = cnt_q[p] + 5'd1;
      end
      lvl       = (cnt_d[p] == 5'd16) ? POST_LEVEL : sr_d[p][0];
      data_d[p] = ~(lvl & CONN[p]);
    end
  end

  always_ff @(posedge MCLK or negedge RST_N) begin
    if (!RST_N) begin
      clk_q  <= 2'b11;
      data_q <= 2'b11;
      for (int p = 0; p < 2; p++) begin
        sr_q[p]  <= '0;
        cnt_q[p] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      clk_q  <= pad_clk;
      data_q <= data_d;
      for (int p = 0; p < 2; p++) begin
        sr_q[p]  <= sr_d[p];
        cnt_q[p] <= cnt_d[p];
      end
    end
  end

  assign JOY1_DI = {1'b1, data_q[0]};
  assign JOY2_DI = {1'b1, data_q[1]};

endmodule

// File: tb/tb_snes_pad_responder.sv
// Self-checking bench for snes_pad_responder: vector table, corner sequences,
// and randomized frames against a bit-index reference model.
module tb_snes_pad_responder;

  localparam logic [3:0] EXT_BITS   = 4'b0000;
  localparam bit         POST_LEVEL = 1'b1;

  logic        MCLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        JOY_STRB = 1'b0;
  logic        JOY1_CLK = 1'b1;
  logic        JOY2_CLK = 1'b1;
  logic [11:0] BTN1 = '0;
  logic [11:0] BTN2 = '0;
  logic [1:0]  CONN = 2'b11;
  logic [11:0] TURBO_MASK1 = '0;
  logic [11:0] TURBO_MASK2 = '0;
  logic [1:0]  JOY1_DI;
  logic [1:0]  JOY2_DI;

  int n_checks = 0;
  int n_fail   = 0;

  snes_pad_responder #(
    .EXT_BITS(EXT_BITS), .POST_LEVEL(POST_LEVEL), .TURBO_DIV(2)
  ) dut (
    .MCLK(MCLK), .RST_N(RST_N), .JOY_STRB(JOY_STRB),
    .JOY1_CLK(JOY1_CLK), .JOY2_CLK(JOY2_CLK),
    .BTN1(BTN1), .BTN2(BTN2), .CONN(CONN),
    .TURBO_MASK1(TURBO_MASK1), .TURBO_MASK2(TURBO_MASK2),
    .JOY1_DI(JOY1_DI), .JOY2_DI(JOY2_DI)
  );

  always #5 MCLK = ~MCLK;

  typedef struct {
    logic [11:0] btn1;
    logic [11:0] btn2;
    logic [1:0]  conn;
    int          pad;
    logic [15:0] exp_line;
    logic        exp_post;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge MCLK);
      #1;
    end
  endtask

  task automatic pulse(input int pad);
    if (pad == 0) JOY1_CLK = 1'b0; else JOY2_CLK = 1'b0;
    tick(2);
    if (pad == 0) JOY1_CLK = 1'b1; else JOY2_CLK = 1'b1;
    tick(1);
  endtask

  task automatic strobe(input int len);
    JOY_STRB = 1'b1;
    tick(len);
    JOY_STRB = 1'b0;
    tick(1);
  endtask

  function automatic logic pad_line(input int pad);
    return (pad == 0) ? JOY1_DI[0] : JOY2_DI[0];
  endfunction

  // Reference: serial bit idx is button idx, then the ID nibble MSB-first, then POST_LEVEL.
  function automatic logic model_line(input logic [11:0] btn, input int idx, input logic conn);
    logic l;
    if (idx >= 16)      l = POST_LEVEL;
    else if (idx < 12)  l = btn[idx];
    else                l = EXT_BITS[15 - idx];
    return ~(l & conn);
  endfunction

  task automatic read_word(input int pad, output logic [15:0] w);
    w[0] = pad_line(pad);
    for (int i = 1; i < 16; i++) begin
      pulse(pad);
      w[i] = pad_line(pad);
    end
  endtask

  initial begin
    vec_t        vecs [6];
    logic [15:0] w;
    logic [11:0] lat [2];
    int          idx [2];

    vecs[0] = '{12'h001, 12'h000, 2'b11, 0, 16'hFFFE, 1'b0};
    vecs[1] = '{12'h000, 12'h800, 2'b11, 1, 16'hF7FF, 1'b0};
    vecs[2] = '{12'hFFF, 12'h000, 2'b11, 0, 16'hF000, 1'b0};
    vecs[3] = '{12'hFFF, 12'h000, 2'b10, 0, 16'hFFFF, 1'b1};
    vecs[4] = '{12'hA5A, 12'h000, 2'b01, 0, 16'hF5A5, 1'b0};
    vecs[5] = '{12'h000, 12'h123, 2'b11, 1, 16'hFEDC, 1'b0};

    // Reset and idle levels.
    tick(3);
    check("reset_joy1", 32'(JOY1_DI), 32'(2'b11));
    check("reset_joy2", 32'(JOY2_DI), 32'(2'b11));
    RST_N = 1'b1;
    tick(4);
    check("idle_joy1", 32'(JOY1_DI), 32'(2'b11));
    check("idle_joy2", 32'(JOY2_DI), 32'(2'b11));

    // Table-driven frames: 16 bits then two POST_LEVEL reads.
    for (int i = 0; i < 6; i++) begin
      BTN1 = vecs[i].btn1;
      BTN2 = vecs[i].btn2;
      CONN = vecs[i].conn;
      strobe(12);
      read_word(vecs[i].pad, w);
      check($sformatf("vec%0d_word", i), 32'(w), 32'(vecs[i].exp_line));
      pulse(vecs[i].pad);
      check($sformatf("vec%0d_post17", i), 32'(pad_line(vecs[i].pad)), 32'(vecs[i].exp_post));
      pulse(vecs[i].pad);
      check($sformatf("vec%0d_post18", i), 32'(pad_line(vecs[i].pad)), 32'(vecs[i].exp_post));
    end

    // Pad 1 clocks must not move pad 2.
    BTN1 = 12'h000; BTN2 = 12'h800; CONN = 2'b11;
    strobe(12);
    for (int i = 0; i < 5; i++) pulse(0);
    check("pad2_isolated", 32'(JOY2_DI), 32'(2'b11));
    read_word(1, w);
    check("pad2_after_pad1_clocks", 32'(w), 32'(16'hF7FF));

    // Button changes after the strobe falls do not affect the frame.
    BTN1 = 12'h000;
    strobe(12);
    BTN1 = 12'hFFF;
    read_word(0, w);
    check("late_btn_frame", 32'(w), 32'(16'hFFFF));
    strobe(12);
    read_word(0, w);
    check("late_btn_next_frame", 32'(w), 32'(16'hF000));

    // Clock rising edge on the last strobe cycle: latch wins, CNT stays 0.
    BTN1 = 12'h002;
    JOY_STRB = 1'b1;
    JOY1_CLK = 1'b0;
    tick(3);
    JOY1_CLK = 1'b1;
    tick(1);
    JOY_STRB = 1'b0;
    tick(1);
    check("strobe_edge_b_level", 32'(JOY1_DI[0]), 32'(1'b1));
    read_word(0, w);
    check("strobe_edge_word", 32'(w), 32'(16'hFFFD));
    pulse(0);
    check("strobe_edge_post", 32'(JOY1_DI[0]), 32'(1'b0));

    // Asynchronous reset mid-read at CNT = 5.
    BTN1 = 12'hFFF;
    strobe(12);
    for (int i = 0; i < 5; i++) pulse(0);
    check("midread_before_reset", 32'(JOY1_DI[0]), 32'(1'b0));
    #2 RST_N = 1'b0;
    #1 check("midread_async_reset", 32'(JOY1_DI), 32'(2'b11));
    tick(2);
    RST_N = 1'b1;
    tick(1);
    w = '1;
    for (int i = 0; i < 15; i++) begin
      pulse(0);
      w[i] = JOY1_DI[0];
    end
    check("after_reset_15_reads", 32'(w), 32'(16'hFFFF));
    pulse(0);
    check("after_reset_cnt_from_0", 32'(JOY1_DI[0]), 32'(1'b0));

    // Randomized frames against the reference model.
    for (int f = 0; f < 30; f++) begin
      BTN1 = 12'($urandom);
      BTN2 = 12'($urandom);
      CONN = 2'($urandom);
      strobe(int'($urandom_range(1, 4)));
      lat[0] = BTN1; lat[1] = BTN2;
      idx[0] = 0;    idx[1] = 0;
      for (int p = 0; p < 2; p++)
        check($sformatf("rand%0d_first_p%0d", f, p), 32'(pad_line(p)),
              32'(model_line(lat[p], 0, CONN[p])));
      for (int k = 0; k < 24; k++) begin
        int pad;
        pad = int'($urandom_range(0, 1));
        if ($urandom_range(0, 3) == 0) BTN1 = 12'($urandom);
        if ($urandom_range(0, 3) == 0) BTN2 = 12'($urandom);
        if ($urandom_range(0, 7) == 0) CONN = 2'($urandom);
        pulse(pad);
        idx[pad]++;
        for (int p = 0; p < 2; p++)
          check($sformatf("rand%0d_k%0d_p%0d", f, k, p), 32'(pad_line(p)),
                32'(model_line(lat[p], idx[p], CONN[p])));
      end
    end

`ifdef SNES_PAD_TURBO_EN
    // Turbo phase toggles every second strobe falling edge.
    RST_N = 1'b0;
    tick(2);
    RST_N = 1'b1;
    tick(1);
    BTN1 = 12'h001; TURBO_MASK1 = 12'h001; CONN = 2'b11;
    for (int f = 1; f <= 8; f++) begin
      strobe(4);
      check($sformatf("turbo_frame%0d", f), 32'(JOY1_DI[0]),
            32'((f == 3 || f == 4 || f == 7 || f == 8) ? 1'b0 : 1'b1));
    end
    TURBO_MASK1 = '0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
